// File: rtl/alu_pkg.sv
// Shared ALU control codes and RV32I opcode constants for the issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_SLT     = 4'b0010,
        ALU_SLTU    = 4'b0011,
        ALU_AND     = 4'b0100,
        ALU_OR      = 4'b0101,
        ALU_XOR     = 4'b0110,
        ALU_SLL     = 4'b0111,
        ALU_SRL     = 4'b1000,
        ALU_SRA     = 4'b1001,
        ALU_ILLEGAL = 4'b1111
    } alu_cntrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // True for the two opcodes this stage knows how to issue.
    function automatic logic is_alu_opcode(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of RV32I OP / OP-IMM fields into an ALU control code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] cntrl,
    output logic       use_imm,
    output logic       illegal
);

    alu_cntrl_e code;
    logic       is_op;
    logic       bad;

    assign is_op   = (opcode == OPC_OP);
    assign use_imm = (opcode == OPC_OP_IMM);

    // Map funct3/funct7_5 to an operation, flagging encodings the ALU cannot do.
    always_comb begin
        code = ALU_ILLEGAL;
        bad  = 1'b0;
        if (!is_alu_opcode(opcode)) begin
            bad = 1'b1;
        end else begin
            // Only SUB and SRA use funct7_5 in OP; in OP-IMM only SLLI forbids it
            // (ADDI's bit 30 is just part of the immediate).
            if (is_op && funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                bad = 1'b1;
            end
            if (!is_op && funct7_5 && (funct3 == 3'b001)) begin
                bad = 1'b1;
            end
            case (funct3)
                3'b000:  code = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  code = ALU_SLL;
                3'b010:  code = ALU_SLT;
                3'b011:  code = ALU_SLTU;
                3'b100:  code = ALU_XOR;
                3'b101:  code = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  code = ALU_OR;
                default: code = ALU_AND;
            endcase
        end
    end

    assign illegal = bad;
    assign cntrl   = bad ? ALU_ILLEGAL : code;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage elastic pipeline: stage 1 drives the external ALU, stage 2 captures its result.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [XLEN-1:0]       rs1_val,
    input  logic [XLEN-1:0]       rs2_val,
    input  logic [XLEN-1:0]       imm,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [3:0]            alu_cntrl,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_illegal
);

    logic [3:0]            dec_cntrl;
    logic                  dec_use_imm;
    logic                  dec_illegal;

    logic                  s1_valid_reg;
    logic [XLEN-1:0]       a_reg;
    logic [XLEN-1:0]       b_reg;
    logic [3:0]            cntrl_reg;
    logic [REG_ADDR_W-1:0] s1_rd_reg;
    logic                  s1_illegal_reg;

    logic                  s2_valid_reg;
    logic [XLEN-1:0]       result_reg;
    logic [REG_ADDR_W-1:0] out_rd_reg;
    logic                  out_illegal_reg;

    logic                  s1_load;
    logic                  s1_adv;
    logic                  s2_adv;

    alu_ctrl_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .cntrl    (dec_cntrl),
        .use_imm  (dec_use_imm),
        .illegal  (dec_illegal)
    );

    // Stage 2 frees up when empty or draining; stage 1 moves only into a free stage 2.
    // in_ready follows out_ready combinationally since there is no skid buffer.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_adv;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign s1_load  = in_valid && in_ready;

    // Stage 1: operand/control registers that feed the combinational ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            cntrl_reg      <= ALU_ILLEGAL;
            s1_rd_reg      <= '0;
            s1_illegal_reg <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg   <= 1'b1;
                a_reg          <= rs1_val;
                b_reg          <= dec_use_imm ? imm : rs2_val;
                cntrl_reg      <= dec_cntrl;
                s1_rd_reg      <= rd;
                s1_illegal_reg <= dec_illegal;
            end else if (s1_adv) begin
                s1_valid_reg   <= 1'b0;
            end
        end
    end

    // Stage 2: capture the ALU result with its tag, held until writeback accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg    <= 1'b0;
            result_reg      <= '0;
            out_rd_reg      <= '0;
            out_illegal_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg      <= s1_illegal_reg ? '0 : alu_result;
                out_rd_reg      <= s1_rd_reg;
                out_illegal_reg <= s1_illegal_reg;
            end
        end
    end

    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign alu_cntrl   = cntrl_reg;
    assign out_valid   = s2_valid_reg;
    assign out_result  = result_reg;
    assign out_rd      = out_rd_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU and ISA-level reference model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_cntrl;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_result = '0;
        case (alu_cntrl)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
    end

    // Instruction-level semantics: what writeback should see for one instruction.
    function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                       input logic [31:0] a, input logic [31:0] r2,
                                       input logic [31:0] im, input logic [4:0] r);
        exp_t        e;
        logic [31:0] b;
        logic        is_op;
        logic        ill;
        is_op = (op == 7'b0110011);
        ill   = !(is_op || op == 7'b0010011);
        if (is_op && f7 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
        if (!is_op && f7 && f3 == 3'd1) ill = 1'b1;
        b = is_op ? r2 : im;
        e.rd = r;
        e.illegal = ill;
        case (f3)
            3'd0: e.result = (is_op && f7) ? a - b : a + b;
            3'd1: e.result = a << b[4:0];
            3'd2: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: e.result = (a < b) ? 32'd1 : 32'd0;
            3'd4: e.result = a ^ b;
            3'd5: e.result = f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: e.result = a | b;
            default: e.result = a & b;
        endcase
        if (ill) e.result = '0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present one instruction from a falling edge; push its expectation when it is accepted.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] r);
        int n = 0;
        bit done = 0;
        @(negedge clk);
        opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_val = a; rs2_val = r2; imm = im; rd = r;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                sb.push_back(ref_model(op, f3, f7, a, r2, im, r));
                @(posedge clk);
                #1 in_valid = 1'b0;
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout in_ready stuck actual=0 required=1");
                    in_valid = 1'b0;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    // Monitor: pop on each output transfer, and require payload held during stalls.
    bit   hold_pending = 0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_payload", {out_result ^ held.result, out_rd ^ held.rd, out_illegal ^ held.illegal}, 32'd0);
            end
            if (out_valid && out_ready) begin
                hold_pending = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual rd=%0d required=none", out_rd);
                end else begin
                    e = sb.pop_front();
                    check("out_result", out_result, e.result);
                    check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    check("out_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
                    $display("OUT rd=%0d result=%h illegal=%0d", out_rd, out_result, out_illegal);
                end
            end else if (out_valid) begin
                hold_pending = 1;
                held = '{out_result, out_rd, out_illegal};
            end else begin
                hold_pending = 0;
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_cntrl", {28'd0, alu_cntrl}, 32'hF);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AND via OP, with pipeline timing
        issue(7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 5'd5);
        check("and_cntrl", {28'd0, alu_cntrl}, 32'h4);
        check("and_alu_a", alu_a, 32'hF0F0F0F0);
        check("and_alu_b", alu_b, 32'h0FF00FF0);
        check("and_no_early_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("and_out_valid", {31'd0, out_valid}, 32'd1);
        check("and_out_result", out_result, 32'h00F000F0);
        check("and_out_rd", {27'd0, out_rd}, 32'd5);

        // ORI selects the immediate
        issue(7'b0010011, 3'b110, 1'b0, 32'h12340000, 32'hFFFFFFFF, 32'h0000ABCD, 5'd9);
        check("ori_alu_b", alu_b, 32'h0000ABCD);
        check("ori_cntrl", {28'd0, alu_cntrl}, 32'h5);

        // Illegal opcode, then a legal SUB
        issue(7'b1100011, 3'b000, 1'b0, 32'h11111111, 32'h22222222, 32'h3, 5'd7);
        check("ill_cntrl", {28'd0, alu_cntrl}, 32'hF);
        issue(7'b0110011, 3'b000, 1'b1, 32'd100, 32'd58, 32'h0, 5'd8);
        check("sub_cntrl", {28'd0, alu_cntrl}, 32'h1);
        issue(7'b0110011, 3'b010, 1'b1, 32'd1, 32'd2, 32'h0, 5'd10);
        check("op_f7_illegal_cntrl", {28'd0, alu_cntrl}, 32'hF);
        issue(7'b0010011, 3'b001, 1'b1, 32'd1, 32'd2, 32'h401, 5'd11);
        check("slli_f7_illegal_cntrl", {28'd0, alu_cntrl}, 32'hF);
        issue(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd12);
        check("addi_f7_cntrl", {28'd0, alu_cntrl}, 32'h0);
        repeat (4) @(negedge clk);

        // Stall: three XORs with writeback blocked
        out_ready = 1'b0;
        issue(7'b0110011, 3'b100, 1'b0, 32'hAAAA0001, 32'h0000FFFF, 32'h0, 5'd1);
        issue(7'b0110011, 3'b100, 1'b0, 32'hAAAA0002, 32'h0000FFFF, 32'h0, 5'd2);
        fork
            issue(7'b0110011, 3'b100, 1'b0, 32'hAAAA0003, 32'h0000FFFF, 32'h0, 5'd3);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk); #1;
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (5) @(negedge clk);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    logic [6:0] op;
                    int sel;
                    sel = $urandom_range(0, 9);
                    op = (sel < 5) ? 7'b0110011 : (sel < 9) ? 7'b0010011 : 7'($urandom);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    issue(op, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
                end
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("drain_empty", sb.size(), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        issue(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'h0, 5'd20);
        issue(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'h0, 5'd21);
        @(negedge clk); #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_cntrl", {28'd0, alu_cntrl}, 32'hF);
        sb.delete();
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
